// File: rtl/npu_pkg.sv
// Shared constants for the NPU self-test bus master: window bases, control codes
// and job-phase state encodings.
package npu_pkg;

  localparam logic [23:0] W_BASE = 24'h3000_00;
  localparam logic [23:0] S_BASE = 24'h3000_01;
  localparam logic [23:0] R_BASE = 24'h3000_02;

  localparam logic [7:0] CTL_RUN = 8'd3;
  localparam logic [7:0] CTL_CLR = 8'd4;

  localparam logic [3:0] MAX_ROWS = 4'd12;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_WGT  = 3'd1;
  localparam state_t ST_ROW  = 3'd2;
  localparam state_t ST_RUN  = 3'd3;
  localparam state_t ST_WAIT = 3'd4;
  localparam state_t ST_RD   = 3'd5;
  localparam state_t ST_RES  = 3'd6;
  localparam state_t ST_CLR  = 3'd7;

  // Control commands live in the top byte of the control register.
  function automatic logic [31:0] ctl_word(input logic [7:0] code);
    return {code, 24'h00_0000};
  endfunction

endpackage

// File: rtl/npu_wb_master_if.sv
// Wishbone classic initiator-side bundle between npu_wb_master and the NPU responder.
interface npu_wb_master_if;

  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );

endinterface

// File: rtl/wb_master_port.sv
// Single-transaction Wishbone engine: one request at a time, mandatory idle cycle
// after every ack, and an ack timeout measured from strobe rise.
module wb_master_port #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] dat,
  output logic        done,
  output logic [15:0] rdata,
  output logic        timeout,
  npu_wb_master_if.master wb
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic          active;
  logic [TW-1:0] tcnt;
  logic          we_r;
  logic [31:0]   adr_r;
  logic [31:0]   dat_r;
  logic          ack_ok;
  logic          expire;

  // An ack in the expiry cycle wins over the timeout.
  assign ack_ok  = active & wb.wbm_ack_i;
  assign expire  = active & ~wb.wbm_ack_i & (tcnt == TW'(TIMEOUT - 1));

  assign done    = ack_ok;
  assign timeout = expire;
  assign rdata   = wb.wbm_dat_i[15:0];

  assign wb.wbm_cyc_o = active;
  assign wb.wbm_stb_o = active;
  assign wb.wbm_we_o  = we_r;
  assign wb.wbm_sel_o = 4'hF;
  assign wb.wbm_adr_o = adr_r;
  assign wb.wbm_dat_o = dat_r;

  // Returning to idle for one clock after ack gives the responder its low-strobe cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      tcnt   <= '0;
      we_r   <= 1'b0;
      adr_r  <= '0;
      dat_r  <= '0;
    end else if (active) begin
      if (ack_ok || expire) begin
        active <= 1'b0;
        tcnt   <= '0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end else if (req) begin
      active <= 1'b1;
      tcnt   <= '0;
      we_r   <= we;
      adr_r  <= adr;
      dat_r  <= dat;
    end
  end

endmodule

// File: rtl/npu_wb_master.sv
// Self-test initiator running one full NPU job: weights, input rows, run, compute
// wait, result read-back onto a valid/ready stream, then clear.
module npu_wb_master #(
  parameter logic [23:0] W_BASE     = npu_pkg::W_BASE,
  parameter logic [23:0] S_BASE     = npu_pkg::S_BASE,
  parameter logic [23:0] R_BASE     = npu_pkg::R_BASE,
  parameter int unsigned NUM_OUT    = 12,
  parameter int unsigned RUN_CYCLES = 16,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  npu_wb_master_if.master wb,
  input  logic        start_i,
  input  logic [71:0] weights_i,
  input  logic [3:0]  n_rows_i,
  input  logic        row_valid_i,
  output logic        row_ready_o,
  input  logic [23:0] row_data_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [15:0] res_data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  import npu_pkg::*;

  localparam int unsigned JW = $clog2(NUM_OUT + 1);
  localparam int unsigned WW = $clog2(RUN_CYCLES + 1);

  state_t        state;
  logic [3:0]    k;
  logic [3:0]    rows;
  logic [3:0]    n_rows;
  logic [71:0]   wts;
  logic [JW-1:0] j;
  logic [WW-1:0] wcnt;
  logic [23:0]   row_lat;
  logic          row_pend;
  logic [15:0]   res_data;
  logic          done_r;
  logic          err_r;

  logic          req;
  logic          pwe;
  logic [31:0]   padr;
  logic [31:0]   pdat;
  logic          pdone;
  logic          ptmo;
  logic [15:0]   prdata;
  logic [7:0]    k_off;
  logic [7:0]    j_off;

  assign k_off = 8'(k) << 2;
  assign j_off = 8'(j) << 2;

  wb_master_port #(.TIMEOUT(TIMEOUT)) u_port (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .req     (req),
    .we      (pwe),
    .adr     (padr),
    .dat     (pdat),
    .done    (pdone),
    .rdata   (prdata),
    .timeout (ptmo),
    .wb      (wb)
  );

  always_comb begin
    req  = 1'b0;
    pwe  = 1'b1;
    padr = '0;
    pdat = '0;
    case (state)
      ST_WGT: begin
        req  = 1'b1;
        padr = {W_BASE, k_off};
        pdat = {24'h00_0000, wts[7:0]};
      end
      ST_ROW: begin
        req  = row_pend;
        padr = {S_BASE, 8'h00};
        pdat = {8'h00, row_lat};
      end
      ST_RUN: begin
        req  = 1'b1;
        padr = {S_BASE, 8'h00};
        pdat = ctl_word(CTL_RUN);
      end
      ST_RD: begin
        req  = 1'b1;
        pwe  = 1'b0;
        padr = {R_BASE, j_off};
      end
      ST_CLR: begin
        req  = 1'b1;
        padr = {S_BASE, 8'h00};
        pdat = ctl_word(CTL_CLR);
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= ST_IDLE;
      k        <= '0;
      rows     <= '0;
      n_rows   <= '0;
      wts      <= '0;
      j        <= '0;
      wcnt     <= '0;
      row_lat  <= '0;
      row_pend <= 1'b0;
      res_data <= '0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (ptmo) begin
        state    <= ST_IDLE;
        err_r    <= 1'b1;
        row_pend <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: if (start_i) begin
            wts      <= weights_i;
            n_rows   <= (n_rows_i > MAX_ROWS) ? MAX_ROWS : n_rows_i;
            err_r    <= 1'b0;
            k        <= '0;
            rows     <= '0;
            j        <= '0;
            row_pend <= 1'b0;
            state    <= ST_WGT;
          end
          ST_WGT: if (pdone) begin
            wts <= {8'h00, wts[71:8]};
            k   <= k + 4'd1;
            if (k == 4'd8) state <= (n_rows == 4'd0) ? ST_RUN : ST_ROW;
          end
          ST_ROW: begin
            if (pdone) begin
              row_pend <= 1'b0;
              rows     <= rows + 4'd1;
              if (rows == n_rows - 4'd1) state <= ST_RUN;
            end else if (row_ready_o && row_valid_i) begin
              row_pend <= 1'b1;
              row_lat  <= row_data_i;
            end
          end
          ST_RUN: if (pdone) begin
            wcnt  <= '0;
            state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (wcnt == WW'(RUN_CYCLES - 1)) state <= ST_RD;
            else wcnt <= wcnt + 1'b1;
          end
          ST_RD: if (pdone) begin
            res_data <= prdata;
            state    <= ST_RES;
          end
          ST_RES: if (res_ready_i) begin
            j     <= j + 1'b1;
            state <= (j == JW'(NUM_OUT - 1)) ? ST_CLR : ST_RD;
          end
          ST_CLR: if (pdone) begin
            done_r <= 1'b1;
            state  <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign row_ready_o = (state == ST_ROW) && !row_pend;
  assign res_valid_o = (state == ST_RES);
  assign res_data_o  = res_data;
  assign busy_o      = (state != ST_IDLE);
  assign done_o      = done_r;
  assign err_o       = err_r;

endmodule

// File: tb/tb_npu_wb_master.sv
// Directed bench for npu_wb_master with a Wishbone responder model, row source and
// result sink; expected bus traffic and results are rebuilt from the job parameters.
module tb_npu_wb_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [71:0] weights_i;
  logic [3:0]  n_rows_i;
  logic        row_valid_i;
  logic        row_ready_o;
  logic [23:0] row_data_i;
  logic        res_valid_o;
  logic        res_ready_i;
  logic [15:0] res_data_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  npu_wb_master_if bus ();

  npu_wb_master dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wb          (bus),
    .start_i     (start_i),
    .weights_i   (weights_i),
    .n_rows_i    (n_rows_i),
    .row_valid_i (row_valid_i),
    .row_ready_o (row_ready_o),
    .row_data_i  (row_data_i),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_data_o  (res_data_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  // Responder: registered ack, optional ack-every-cycle mode, optional stall on weight 3.
  logic resp_fast = 1'b0;
  logic stall_en  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) bus.wbm_ack_i <= 1'b0;
    else bus.wbm_ack_i <= bus.wbm_cyc_o & bus.wbm_stb_o & (resp_fast | ~bus.wbm_ack_i)
                          & ~(stall_en && bus.wbm_adr_o == 32'h3000_000C);
  end

  assign bus.wbm_dat_i = (bus.wbm_adr_o[31:8] == 24'h3000_02)
                         ? {16'hA5A5, 16'h0100 + 16'(bus.wbm_adr_o[7:2])} : 32'h0;

  function automatic logic [23:0] row_val(input int i);
    row_val = {8'(3 * i + 3), 8'(3 * i + 2), 8'(3 * i + 1)};
  endfunction

  // Bus monitor, sampled on the falling edge.
  int          cyc_cnt = 0;
  logic [31:0] lg_adr [0:511];
  logic [31:0] lg_dat [0:511];
  logic        lg_we  [0:511];
  int          lg_n = 0;
  int          done_cnt = 0;
  int          rr_cnt = 0;
  int          idle_viol = 0;
  int          rise_cyc = 0;
  logic        prev_hs = 1'b0;
  logic        prev_stb = 1'b0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (bus.wbm_cyc_o !== bus.wbm_stb_o) idle_viol++;
    if (prev_hs && bus.wbm_stb_o) idle_viol++;
    prev_hs = bus.wbm_cyc_o & bus.wbm_stb_o & bus.wbm_ack_i;
    if (prev_hs && lg_n < 512) begin
      lg_adr[lg_n] = bus.wbm_adr_o;
      lg_dat[lg_n] = bus.wbm_dat_o;
      lg_we[lg_n]  = bus.wbm_we_o;
      lg_n++;
    end
    if (bus.wbm_stb_o && !prev_stb && bus.wbm_adr_o == 32'h3000_000C) rise_cyc = cyc_cnt;
    prev_stb = bus.wbm_stb_o;
    if (done_o) done_cnt++;
    if (row_ready_o) rr_cnt++;
  end

  // Row source.
  int   row_idx = 0;
  int   row_base = 0;
  int   row_lim = 0;
  logic row_hs = 1'b0;

  always @(negedge clk) begin
    if (row_hs) row_idx++;
    row_valid_i = (row_idx - row_base) < row_lim;
    row_data_i  = row_val(row_idx - row_base);
    row_hs      = row_valid_i && row_ready_o;
  end

  // Result sink with optional 20-cycle stall on result 5.
  logic [15:0] res_log [0:255];
  int          res_n = 0;
  int          res_base = 0;
  logic        bp_en = 1'b0;
  int          bp_cnt = 0;
  int          bp_viol = 0;

  always @(negedge clk) begin
    if (bp_en && res_valid_o && (res_n - res_base) == 5 && bp_cnt < 20) begin
      if (res_data_o !== 16'h0105 || bus.wbm_cyc_o !== 1'b0) bp_viol++;
      bp_cnt++;
      res_ready_i = 1'b0;
    end else begin
      res_ready_i = 1'b1;
    end
    if (res_valid_o && res_ready_i && res_n < 256) begin
      res_log[res_n] = res_data_o;
      res_n++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int lg_b, done_b, rr_b;

  task automatic start_job(input logic [3:0] n);
    @(negedge clk);
    lg_b      = lg_n;
    res_base  = res_n;
    done_b    = done_cnt;
    rr_b      = rr_cnt;
    row_base  = row_idx;
    row_lim   = (n > 4'd12) ? 12 : int'(n);
    weights_i = 72'h09_0807_0605_0403_0201;
    n_rows_i  = n;
    start_i   = 1'b1;
    @(negedge clk);
    start_i   = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n;
    n = 0;
    while (busy_o && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_finish"}, 32'(busy_o), 32'h0);
    @(negedge clk);
  endtask

  task automatic chk_log(input int base, input int nr, input string tag);
    int e;
    e = base;
    chk({tag, "_count"}, 32'(lg_n - base), 32'(nr + 23));
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("%s_w%0d_adr", tag, k), lg_adr[e], 32'h3000_0000 + 32'(4 * k));
      chk($sformatf("%s_w%0d_dat", tag, k), lg_dat[e], 32'(k + 1));
      chk($sformatf("%s_w%0d_we", tag, k), 32'(lg_we[e]), 32'h1);
      e++;
    end
    for (int r = 0; r < nr; r++) begin
      chk($sformatf("%s_r%0d_adr", tag, r), lg_adr[e], 32'h3000_0100);
      chk($sformatf("%s_r%0d_dat", tag, r), lg_dat[e], {8'h00, row_val(r)});
      e++;
    end
    chk({tag, "_run_adr"}, lg_adr[e], 32'h3000_0100);
    chk({tag, "_run_dat"}, lg_dat[e], 32'h0300_0000);
    e++;
    for (int j = 0; j < 12; j++) begin
      chk($sformatf("%s_rd%0d_adr", tag, j), lg_adr[e], 32'h3000_0200 + 32'(4 * j));
      chk($sformatf("%s_rd%0d_we", tag, j), 32'(lg_we[e]), 32'h0);
      e++;
    end
    chk({tag, "_clr_adr"}, lg_adr[e], 32'h3000_0100);
    chk({tag, "_clr_dat"}, lg_dat[e], 32'h0400_0000);
    chk({tag, "_clr_we"}, 32'(lg_we[e]), 32'h1);
  endtask

  task automatic chk_res(input int base, input string tag);
    chk({tag, "_res_count"}, 32'(res_n - base), 32'd12);
    for (int j = 0; j < 12; j++)
      chk($sformatf("%s_res%0d", tag, j), 32'(res_log[base + j]), 32'h0100 + 32'(j));
  endtask

  initial begin
    int n;
    int errc;
    rst       = 1'b1;
    start_i   = 1'b0;
    weights_i = '0;
    n_rows_i  = '0;
    #2;
    chk("rst_cyc", 32'(bus.wbm_cyc_o), 32'h0);
    chk("rst_stb", 32'(bus.wbm_stb_o), 32'h0);
    chk("rst_we", 32'(bus.wbm_we_o), 32'h0);
    chk("rst_sel", 32'(bus.wbm_sel_o), 32'hF);
    chk("rst_adr", bus.wbm_adr_o, 32'h0);
    chk("rst_dat", bus.wbm_dat_o, 32'h0);
    chk("rst_row_ready", 32'(row_ready_o), 32'h0);
    chk("rst_res_valid", 32'(res_valid_o), 32'h0);
    chk("rst_res_data", 32'(res_data_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Nominal job, three rows, backpressure on result 5.
    bp_en = 1'b1;
    start_job(4'd3);
    chk("A_busy", 32'(busy_o), 32'h1);
    wait_idle("A", 3000);
    bp_en = 1'b0;
    chk_log(lg_b, 3, "A");
    chk_res(res_base, "A");
    chk("A_done", 32'(done_cnt - done_b), 32'd1);
    chk("A_bp_cycles", 32'(bp_cnt), 32'd20);
    chk("A_bp_stable", 32'(bp_viol), 32'd0);
    chk("A_err", 32'(err_o), 32'h0);

    // No rows: run write directly after the last weight.
    start_job(4'd0);
    wait_idle("B", 3000);
    chk_log(lg_b, 0, "B");
    chk_res(res_base, "B");
    chk("B_row_ready", 32'(rr_cnt - rr_b), 32'd0);
    chk("B_done", 32'(done_cnt - done_b), 32'd1);

    // Ack on every strobed cycle, row count clamped from 15 to 12.
    resp_fast = 1'b1;
    start_job(4'd15);
    wait_idle("C", 3000);
    resp_fast = 1'b0;
    chk_log(lg_b, 12, "C");
    chk_res(res_base, "C");
    chk("C_done", 32'(done_cnt - done_b), 32'd1);
    chk("idle_rule", 32'(idle_viol), 32'd0);

    // Responder never acks the fourth weight write.
    stall_en = 1'b1;
    start_job(4'd2);
    n = 0;
    while (!err_o && n < 600) begin
      @(negedge clk);
      n++;
    end
    errc = cyc_cnt;
    chk("D_tmo_delay", 32'(errc - rise_cyc), 32'd255);
    chk("D_cyc", 32'(bus.wbm_cyc_o), 32'h0);
    chk("D_stb", 32'(bus.wbm_stb_o), 32'h0);
    chk("D_busy", 32'(busy_o), 32'h0);
    chk("D_res_valid", 32'(res_valid_o), 32'h0);
    chk("D_row_ready", 32'(row_ready_o), 32'h0);
    @(negedge clk);
    stall_en = 1'b0;
    chk("D_done", 32'(done_cnt - done_b), 32'd0);
    chk("D_writes", 32'(lg_n - lg_b), 32'd3);
    repeat (5) @(negedge clk);
    chk("D_err_sticky", 32'(err_o), 32'h1);

    // A new start clears the error and completes a job.
    start_job(4'd1);
    chk("E_err_clr", 32'(err_o), 32'h0);
    wait_idle("E", 3000);
    chk_log(lg_b, 1, "E");
    chk_res(res_base, "E");
    chk("E_done", 32'(done_cnt - done_b), 32'd1);

    // Asynchronous reset while a result read is on the bus.
    start_job(4'd2);
    n = 0;
    while (!(bus.wbm_stb_o && bus.wbm_adr_o[31:8] == 24'h3000_02) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("F_in_read", 32'(bus.wbm_stb_o), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("F_cyc", 32'(bus.wbm_cyc_o), 32'h0);
    chk("F_stb", 32'(bus.wbm_stb_o), 32'h0);
    chk("F_res_valid", 32'(res_valid_o), 32'h0);
    chk("F_busy", 32'(busy_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    start_job(4'd2);
    wait_idle("G", 3000);
    chk_log(lg_b, 2, "G");
    chk_res(res_base, "G");
    chk("G_done", 32'(done_cnt - done_b), 32'd1);
    chk("G_err", 32'(err_o), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at checks=%0d failures=%0d", checks, fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/npu_wb_master.md
Name: npu_wb_master

Overview:
- Wishbone classic initiator that runs one complete job on the NPU systolic-array peripheral:
  - loads the 9 weights;
  - streams input rows;
  - issues the run command and waits the compute window;
  - reads results back and issues the clear command.
- Sits on the bus side opposite the NPU responder, for bring-up/self-test without CPU software.
- Hands results to the local logic on a valid/ready stream.

Parameters:
- W_BASE, 24'h3000_00: upper 24 address bits of the weight window.
- S_BASE, 24'h3000_01: upper 24 address bits of the input/control window.
- R_BASE, 24'h3000_02: upper 24 address bits of the result window.
- NUM_OUT, 12: number of result words read per job.
- RUN_CYCLES, 16: idle cycles between the run command and the first result read.
- TIMEOUT, 255: maximum cycles to wait for an ack.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  asynchronous active-high reset.
- wbm_cyc_o  out  1  bus cycle.
- wbm_stb_o  out  1  strobe.
- wbm_we_o  out  1  write enable.
- wbm_sel_o  out  4  byte select, always 4'hF.
- wbm_adr_o  out  32  address.
- wbm_dat_o  out  32  write data.
- wbm_dat_i  in  32  read data.
- wbm_ack_i  in  1  ack.
- start_i  in  1  job start pulse.
- weights_i  in  72  9 weights: byte k = weights_i[8k+7:8k], sampled at start.
- n_rows_i  in  4  rows to stream, sampled at start.
- row_valid_i  in  1  input row valid.
- row_ready_o  out  1  input row accepted.
- row_data_i  in  24  row bytes {in3,in2,in1}.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  result consumed.
- res_data_o  out  16  result value (wbm_dat_i[15:0]).
- busy_o  out  1  job in progress.
- done_o  out  1  one-cycle pulse at job end.
- err_o  out  1  sticky ack-timeout flag.

Behaviour:
- Reset (asynchronous, immediate): all outputs are 0, except wbm_sel_o = 4'hF. State is IDLE and all counters are 0.
- Bus rules:
  - One transaction at a time; cyc_o and stb_o are asserted together.
  - Address, data and we_o are stable until ack.
  - The cycle after ack, cyc_o and stb_o are low for at least one cycle. This is mandatory because the responder registers ack from stb.
  - wbm_ack_i is ignored while stb_o is low.
- IDLE:
  - start_i latches weights_i and n_rows_i; n_rows values >12 are clamped to 12.
  - Clears err_o, sets busy_o, goes to WGT.
  - start_i is ignored while busy_o is high.
- WGT: 9 writes, k = 0..8.
  - Address {W_BASE, k*4}; data {24'h0, weight k}.
  - Then ROW, or RUN if n_rows = 0.
- ROW:
  - row_ready_o = 1 only in ROW, while no bus transaction is pending.
  - On a row_valid_i & row_ready_o handshake: latch row_data_i, write address {S_BASE, 8'h00}, data {8'h00, row}.
  - Repeat n_rows times; row_ready_o stays 0 while the write is pending.
  - No time limit on waiting for row_valid_i.
- RUN:
  - Write address {S_BASE, 8'h00}, data 32'h0300_0000 (control field = 3).
  - Then WAIT.
- WAIT: count RUN_CYCLES cycles, then RD.
- RD / RES: for j = 0..NUM_OUT-1:
  - Read address {R_BASE, j*4}.
  - On ack: capture wbm_dat_i[15:0] into res_data_o, assert res_valid_o, go to RES.
  - RES holds res_valid_o and res_data_o stable until res_ready_i. The next read is not started before that handshake.
  - Back-to-back results therefore have at least 2 idle cycles between them.
- CLR:
  - Write address {S_BASE, 8'h00}, data 32'h0400_0000 (control field = 4).
  - Then pulse done_o for 1 cycle, drop busy_o, return to IDLE.
- Timeout:
  - An ack counter runs from stb_o rise. If TIMEOUT cycles pass with no ack: drop cyc/stb, set err_o, drop busy_o, return to IDLE.
  - On timeout: no done_o pulse and no CLR write; res_valid_o and row_ready_o are forced to 0.
- Simultaneous events: ack arriving in the same cycle as timeout expiry counts as success.
- Counters: k in 4 bits, rows in 4 bits, j in $clog2(NUM_OUT+1) bits, wait/timeout counters sized from their parameters. No wrap-around is reachable.

Decomposition:
- Shared package npu_pkg holds:
  - window base constants W_BASE, S_BASE, R_BASE;
  - control codes CTL_RUN = 3 and CTL_CLR = 4;
  - the state enum (IDLE, WGT, ROW, RUN, WAIT, RD, RES, CLR).
- One natural sub-module, wb_master_port: single-transaction engine.
  - Inputs: req, we, adr, dat.
  - Outputs: done, rdata, timeout.
  - Owns the ack/idle-cycle/timeout rules. The top-level FSM sequences job phases only.

Test Plan:
- Nominal job:
  - Stimulus: start with weights 1..9, n_rows = 3, rows 24'h030201, 24'h060504, 24'h090807; a responder model returning 16'h0100 + j.
  - Required: writes at 0x3000_0000, 0x3000_0004 … 0x3000_0020, then three writes to 0x3000_0100, then 0x0300_0000, then reads 0x3000_0200 … 0x3000_022C; results 0x0100 … 0x010B in order; then 0x0400_0000; done_o pulses once.
- n_rows = 0: no row writes, row_ready_o never rises; the run write follows the 9th weight write.
- Backpressure:
  - Stimulus: res_ready_i low for 20 cycles on result 5.
  - Required: res_data_o stable, no bus activity, no lost or duplicated result.
- Idle-cycle rule: responder acks every cycle that stb is high → every ack is followed by stb low; exactly 9+n+1+12+1 acks are counted.
- Timeout: responder never acks the 4th weight write → err_o = 1 at cycle 255 after stb rise, bus released, no done_o; a new start clears err_o.
- Reset mid-RD: assert wb_rst_i asynchronously → cyc, stb, res_valid_o and busy_o go low without waiting for a clock edge; after reset release, start runs a full job.
